// File: rtl/ptcalc_mul_arbiter.sv
// ptcalc_mul_arbiter: round-robin arbiter sharing one 16-bit unsigned x 26-bit
// signed multiplier among NUM_REQ requesters. Two-stage stall-able pipeline
// (operand register, product register) with a single valid/ready result bus.
//
// Ports:
//   ap_clk, ap_rst_n     rising-edge clock, synchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b/req_tag  packed per-requester operands and user tag
//   res_valid/res_ready  result handshake
//   res_p, res_ovf       41-bit wrapped product and overflow flag
//   res_src, res_tag     originating requester index and its tag
//   busy                 either pipeline stage holds a valid entry
module ptcalc_mul_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned SRC_W   = 2
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*16-1:0]    req_a,
   input  logic [NUM_REQ*26-1:0]    req_b,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [40:0]              res_p,
   output logic                     res_ovf,
   output logic [SRC_W-1:0]         res_src,
   output logic [TAG_W-1:0]         res_tag,
   output logic                     busy
);

   localparam int unsigned A_W = 16;
   localparam int unsigned B_W = 26;
   localparam int unsigned P_W = 41;
   localparam int unsigned X_W = 42;

   // Stage 1: operand register
   logic             s1_valid_q, s1_valid_d;
   logic [A_W-1:0]   s1_a_q,     s1_a_d;
   logic [B_W-1:0]   s1_b_q,     s1_b_d;
   logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
   logic [SRC_W-1:0] s1_src_q,   s1_src_d;

   // Stage 2: product register, drives the result bus directly
   logic             s2_valid_q, s2_valid_d;
   logic [P_W-1:0]   res_p_q,    res_p_d;
   logic             res_ovf_q,  res_ovf_d;
   logic [SRC_W-1:0] res_src_q,  res_src_d;
   logic [TAG_W-1:0] res_tag_q,  res_tag_d;

   logic [SRC_W-1:0] ptr_q, ptr_d;

   logic             adv_c;
   logic             grant_found_c;
   logic [SRC_W-1:0] grant_idx_c;
   logic             accept_c;
   logic [A_W-1:0]   sel_a_c;
   logic [B_W-1:0]   sel_b_c;
   logic [TAG_W-1:0] sel_tag_c;

   logic signed [X_W-1:0] a_ext_c, b_ext_c, prod_c;

   // Pipeline moves whenever stage 2 is empty or being drained this cycle
   assign adv_c = !s2_valid_q || res_ready;

   // Round-robin scan starting at ptr; wraps modulo NUM_REQ
   always_comb begin
      logic [SRC_W:0]   sum;
      logic [SRC_W-1:0] scan_idx;
      grant_found_c = 1'b0;
      grant_idx_c   = '0;
      sum           = '0;
      scan_idx      = '0;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
         if (sum >= (SRC_W+1)'(NUM_REQ)) begin
            sum = sum - (SRC_W+1)'(NUM_REQ);
         end
         scan_idx = sum[SRC_W-1:0];
         if (!grant_found_c && req_valid[scan_idx]) begin
            grant_found_c = 1'b1;
            grant_idx_c   = scan_idx;
         end
      end
   end

   // Grant is suppressed during reset and while the pipeline is stalled
   assign accept_c = ap_rst_n && grant_found_c && adv_c;

   always_comb begin
      req_ready = '0;
      if (accept_c) begin
         req_ready[grant_idx_c] = 1'b1;
      end
   end

   // Operand mux for the winning requester
   always_comb begin
      sel_a_c   = '0;
      sel_b_c   = '0;
      sel_tag_c = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (grant_idx_c == SRC_W'(i)) begin
            sel_a_c   = req_a[i*A_W +: A_W];
            sel_b_c   = req_b[i*B_W +: B_W];
            sel_tag_c = req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   // Exact product always fits in 42 bits: 17-bit signed x 26-bit signed
   assign a_ext_c = $signed({(X_W-A_W)'(0), s1_a_q});
   assign b_ext_c = $signed({{(X_W-B_W){s1_b_q[B_W-1]}}, s1_b_q});
   assign prod_c  = a_ext_c * b_ext_c;

   // Next-state logic for both stages and the round-robin pointer
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_tag_d   = s1_tag_q;
      s1_src_d   = s1_src_q;
      s2_valid_d = s2_valid_q;
      res_p_d    = res_p_q;
      res_ovf_d  = res_ovf_q;
      res_src_d  = res_src_q;
      res_tag_d  = res_tag_q;
      ptr_d      = ptr_q;

      if (adv_c) begin
         s1_valid_d = accept_c;
         if (accept_c) begin
            s1_a_d   = sel_a_c;
            s1_b_d   = sel_b_c;
            s1_tag_d = sel_tag_c;
            s1_src_d = grant_idx_c;
            ptr_d    = (grant_idx_c == SRC_W'(NUM_REQ-1)) ? '0
                                                          : grant_idx_c + SRC_W'(1);
         end

         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            res_p_d   = prod_c[P_W-1:0];
            // Overflow when the top two bits of the exact product disagree
            res_ovf_d = prod_c[X_W-1] ^ prod_c[X_W-2];
            res_src_d = s1_src_q;
            res_tag_d = s1_tag_q;
         end
      end
   end

   // State registers
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_tag_q   <= '0;
         s1_src_q   <= '0;
         s2_valid_q <= 1'b0;
         res_p_q    <= '0;
         res_ovf_q  <= 1'b0;
         res_src_q  <= '0;
         res_tag_q  <= '0;
         ptr_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_tag_q   <= s1_tag_d;
         s1_src_q   <= s1_src_d;
         s2_valid_q <= s2_valid_d;
         res_p_q    <= res_p_d;
         res_ovf_q  <= res_ovf_d;
         res_src_q  <= res_src_d;
         res_tag_q  <= res_tag_d;
         ptr_q      <= ptr_d;
      end
   end

   assign res_valid = s2_valid_q;
   assign res_p     = res_p_q;
   assign res_ovf   = res_ovf_q;
   assign res_src   = res_src_q;
   assign res_tag   = res_tag_q;
   assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_ptcalc_mul_arbiter.sv
// Testbench for ptcalc_mul_arbiter: directed product vectors from a table plus
// hand-written sequences for reset, round-robin, backpressure and mid-flight reset.
module tb_ptcalc_mul_arbiter;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned SRC_W   = 2;

   logic                     ap_clk = 1'b0;
   logic                     ap_rst_n;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ*16-1:0]    req_a;
   logic [NUM_REQ*26-1:0]    req_b;
   logic [NUM_REQ*TAG_W-1:0] req_tag;
   logic                     res_valid;
   logic                     res_ready;
   logic [40:0]              res_p;
   logic                     res_ovf;
   logic [SRC_W-1:0]         res_src;
   logic [TAG_W-1:0]         res_tag;
   logic                     busy;

   int n_tests = 0;
   int n_fail  = 0;

   ptcalc_mul_arbiter #(
      .NUM_REQ (NUM_REQ),
      .TAG_W   (TAG_W),
      .SRC_W   (SRC_W)
   ) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_tag   (req_tag),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_p     (res_p),
      .res_ovf   (res_ovf),
      .res_src   (res_src),
      .res_tag   (res_tag),
      .busy      (busy)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      int                src;
      logic [15:0]       a;
      logic signed [25:0] b;
      logic [3:0]        tag;
      logic signed [40:0] exp_p;
      logic              exp_ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [15:0] a, input logic [25:0] b,
                          input logic [3:0] tag);
      req_a[16*i +: 16]      = a;
      req_b[26*i +: 26]      = b;
      req_tag[TAG_W*i +: TAG_W] = tag;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge ap_clk);
   endtask

   initial begin
      logic [3:0] oh;

      // Hand-computed products; b=16777215 with a=65535 stays below 2^40, so no overflow
      vecs[0] = '{2, 16'd3,     -26'sd5,        4'hA, -41'sd15,            1'b0};
      vecs[1] = '{0, 16'd65535, -26'sd33554432, 4'h1, 41'sd33554432,       1'b1};
      vecs[2] = '{1, 16'd65535, 26'sd16777215,  4'h2, 41'sd1099494785025,  1'b0};
      vecs[3] = '{3, 16'd1,     -26'sd33554432, 4'hF, -41'sd33554432,      1'b0};
      vecs[4] = '{2, 16'd65535, 26'sd33554431,  4'h5, -41'sd33619967,      1'b1};
      vecs[5] = '{0, 16'd0,     -26'sd1,        4'h0, 41'sd0,              1'b0};
      vecs[6] = '{1, 16'd65535, -26'sd1,        4'h7, -41'sd65535,         1'b0};

      // Reset with every requester asking and the pipeline able to advance
      ap_rst_n  = 1'b0;
      res_ready = 1'b1;
      req_valid = '1;
      req_a = '0; req_b = '0; req_tag = '0;
      for (int i = 0; i < 4; i++) set_req(i, 16'(i + 1), 26'sd1, 4'(i));
      for (int c = 0; c < 3; c++) begin
         @(negedge ap_clk); #1;
         check("rst_req_ready", 64'(req_ready), 64'd0);
         check("rst_res_valid", 64'(res_valid), 64'd0);
         check("rst_busy",      64'(busy),      64'd0);
      end
      check("rst_res_p",   {23'd0, res_p}, 64'd0);
      check("rst_res_ovf", 64'(res_ovf),   64'd0);
      check("rst_res_src", 64'(res_src),   64'd0);
      check("rst_res_tag", 64'(res_tag),   64'd0);

      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      #1 check("first_grant", 64'(req_ready), 64'b0001);
      @(negedge ap_clk);
      req_valid = '0;
      idle(3);

      // Table-driven product vectors, one isolated request each
      for (int v = 0; v < 7; v++) begin
         @(negedge ap_clk);
         req_a = '0; req_b = '0; req_tag = '0;
         set_req(vecs[v].src, vecs[v].a, vecs[v].b, vecs[v].tag);
         req_valid = '0;
         req_valid[vecs[v].src] = 1'b1;
         oh = 4'b0001 << vecs[v].src;
         #1 check($sformatf("v%0d_grant", v), 64'(req_ready), 64'(oh));
         @(negedge ap_clk);
         req_valid = '0;
         #1;
         check($sformatf("v%0d_lat1_valid", v), 64'(res_valid), 64'd0);
         check($sformatf("v%0d_lat1_busy", v),  64'(busy),      64'd1);
         @(negedge ap_clk); #1;
         check($sformatf("v%0d_valid", v), 64'(res_valid), 64'd1);
         check($sformatf("v%0d_p", v),     {23'd0, res_p}, {23'd0, vecs[v].exp_p});
         check($sformatf("v%0d_ovf", v),   64'(res_ovf),   64'(vecs[v].exp_ovf));
         check($sformatf("v%0d_src", v),   64'(res_src),   64'(vecs[v].src));
         check($sformatf("v%0d_tag", v),   64'(res_tag),   64'(vecs[v].tag));
      end
      @(negedge ap_clk); #1;
      check("vec_drained", 64'(busy), 64'd0);

      // Round-robin with all requesters continuously valid, from a fresh pointer
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 16'(i + 1), 26'sd1, 4'(i + 8));
      req_valid = '1;
      res_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) @(negedge ap_clk);
         #1;
         oh = 4'b0001 << (c % 4);
         check($sformatf("rr%0d_grant", c), 64'(req_ready), 64'(oh));
         if (c >= 2) begin
            check($sformatf("rr%0d_valid", c), 64'(res_valid), 64'd1);
            check($sformatf("rr%0d_src", c),   64'(res_src),   64'((c - 2) % 4));
            check($sformatf("rr%0d_tag", c),   64'(res_tag),   64'((c - 2) % 4 + 8));
            check($sformatf("rr%0d_p", c),     {23'd0, res_p}, 64'((c - 2) % 4 + 1));
         end
      end
      @(negedge ap_clk);
      req_valid = '0;
      #1 check("rr_tail_src2", 64'(res_src), 64'd2);
      @(negedge ap_clk); #1;
      check("rr_tail_src3", 64'(res_src), 64'd3);
      check("rr_tail_valid", 64'(res_valid), 64'd1);
      @(negedge ap_clk); #1;
      check("rr_drained_valid", 64'(res_valid), 64'd0);
      check("rr_drained_busy",  64'(busy),      64'd0);

      // Backpressure: two accepts fill the pipe, then everything stalls
      @(negedge ap_clk);
      res_ready = 1'b0;
      req_valid = '1;
      #1 check("bp_grant0", 64'(req_ready), 64'b0001);
      @(negedge ap_clk); #1;
      check("bp_grant1", 64'(req_ready), 64'b0010);
      check("bp_valid1", 64'(res_valid), 64'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge ap_clk); #1;
         check($sformatf("bp_stall%0d_ready", c), 64'(req_ready), 64'd0);
         check($sformatf("bp_stall%0d_valid", c), 64'(res_valid), 64'd1);
         check($sformatf("bp_stall%0d_src", c),   64'(res_src),   64'd0);
         check($sformatf("bp_stall%0d_p", c),     {23'd0, res_p}, 64'd1);
         check($sformatf("bp_stall%0d_tag", c),   64'(res_tag),   64'd8);
      end
      // Requesters 2 and 3 withdraw before being served
      @(negedge ap_clk);
      res_ready = 1'b1;
      req_valid = '0;
      #1;
      check("bp_rel_src0",   64'(res_src),   64'd0);
      check("bp_rel_valid0", 64'(res_valid), 64'd1);
      @(negedge ap_clk); #1;
      check("bp_rel_src1",   64'(res_src),   64'd1);
      check("bp_rel_p1",     {23'd0, res_p}, 64'd2);
      check("bp_rel_valid1", 64'(res_valid), 64'd1);
      @(negedge ap_clk); #1;
      check("bp_rel_empty", 64'(res_valid), 64'd0);
      check("bp_rel_busy",  64'(busy),      64'd0);

      // Reset with both stages full; pointer currently at 2
      @(negedge ap_clk);
      res_ready = 1'b0;
      req_valid = '1;
      #1 check("mf_grant2", 64'(req_ready), 64'b0100);
      @(negedge ap_clk); #1;
      check("mf_grant3", 64'(req_ready), 64'b1000);
      @(negedge ap_clk); #1;
      check("mf_full_busy", 64'(busy),    64'd1);
      check("mf_full_src",  64'(res_src), 64'd2);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1 check("mf_rst_ready", 64'(req_ready), 64'd0);
      @(negedge ap_clk);
      ap_rst_n  = 1'b1;
      req_valid = '0;
      res_ready = 1'b1;
      #1;
      check("mf_post_valid0", 64'(res_valid), 64'd0);
      check("mf_post_busy0",  64'(busy),      64'd0);
      @(negedge ap_clk); #1;
      check("mf_post_valid1", 64'(res_valid), 64'd0);
      req_valid = '1;
      #1 check("mf_ptr_reset", 64'(req_ready), 64'b0001);
      @(negedge ap_clk);
      req_valid = '0;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
